float_group_sequencer: RTL

//  Accepts one WIDTH_IN-lane float vector plus a per-lane active mask and issues it as WIDTH_OUT-lane groups.

---
 rtl/float_seq_pkg.sv | 22 ++
 rtl/float_group_sequencer_pick.sv | 35 +++
 rtl/float_group_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/float_seq_pkg.sv
// Shared types and helpers for the float group sequencer.
//   fp_lane_t  : one float lane at the default lane width
//   seq_state_t: sequencer FSM states
//   grp_any()  : OR-reduce the mask bits belonging to one group
package float_seq_pkg;

  localparam int FBITS_DEF = 18;
  localparam int MASK_MAX  = 64;

  typedef logic [FBITS_DEF-1:0] fp_lane_t;

  typedef enum logic {IDLE, ISSUE} seq_state_t;

  // mask is zero-extended to MASK_MAX bits by the caller; wout < MASK_MAX
  function automatic logic grp_any(input logic [MASK_MAX-1:0] mask,
                                   input int g, input int wout);
    logic [MASK_MAX-1:0] sel;
    sel = (64'd1 << wout) - 64'd1;
    return |((mask >> (g * wout)) & sel);
  endfunction

endpackage

// File: rtl/float_group_sequencer_pick.sv
// Combinational group search over a lane mask.
//   mask    : WIDTH_IN lane-active bits
//   cur     : group the search starts from
//   incl    : 1 -> cur itself is a candidate, 0 -> search strictly above cur
//   nxt     : lowest qualifying group with any mask bit set
//   found   : a qualifying group exists
module float_group_pick
  import float_seq_pkg::*;
#(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 4,
  localparam int NG = WIDTH_IN / WIDTH_OUT,
  localparam int GW = $clog2(NG)
) (
  input  logic [WIDTH_IN-1:0] mask,
  input  logic [GW-1:0]       cur,
  input  logic                incl,
  output logic [GW-1:0]       nxt,
  output logic                found
);

  // Descending scan so the lowest qualifying group is the last to write.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (grp_any(64'(mask), g, WIDTH_OUT) &&
          (g > int'(cur) || (incl && g == int'(cur)))) begin
        nxt   = GW'(g);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/float_group_sequencer.sv
// Narrows one WIDTH_IN-lane float vector into WIDTH_OUT-lane groups, one
// group per cycle in ascending order, under valid/ready backpressure.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : input vector handshake
//   in_data, in_mask              : input lanes and per-lane active bits
//   out_valid/out_ready           : issued-group handshake (registered slot)
//   out_data, out_mask, out_group : issued group lanes, mask bits, index
//   out_last                      : final group of the current vector
module float_group_sequencer
  import float_seq_pkg::*;
#(
  parameter int WIDTH_IN   = 16,
  parameter int WIDTH_OUT  = 4,
  parameter int FBITS      = 18,
  parameter bit SKIP_EMPTY = 1'b1,
  localparam int GW = $clog2(WIDTH_IN / WIDTH_OUT)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH_IN-1:0][FBITS-1:0]     in_data,
  input  logic [WIDTH_IN-1:0]                in_mask,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH_OUT-1:0][FBITS-1:0]    out_data,
  output logic [WIDTH_OUT-1:0]               out_mask,
  output logic [GW-1:0]                      out_group,
  output logic                               out_last
);

  seq_state_t state, state_nxt;
  logic [GW-1:0]                   grp;
  logic [WIDTH_IN-1:0][FBITS-1:0]  cap_data;
  logic [WIDTH_IN-1:0]             cap_mask;

  logic          slot_free, issuing, accept;
  logic [GW-1:0] first_grp, nxt_grp;
  logic          first_found, nxt_found;
  logic [WIDTH_IN-1:0] first_search, nxt_search;

  // With SKIP_EMPTY=0 every group counts as active, so the same search
  // yields "first = 0" and "next = grp+1, last at max".
  assign first_search = SKIP_EMPTY ? in_mask  : '1;
  assign nxt_search   = SKIP_EMPTY ? cap_mask : '1;

  float_group_pick #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT)) u_first (
    .mask (first_search),
    .cur  ('0),
    .incl (1'b1),
    .nxt  (first_grp),
    .found(first_found)
  );

  float_group_pick #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT)) u_next (
    .mask (nxt_search),
    .cur  (grp),
    .incl (1'b0),
    .nxt  (nxt_grp),
    .found(nxt_found)
  );

  assign slot_free = !out_valid || out_ready;
  assign issuing   = (state == ISSUE) && slot_free;
  // Opening the input on the last-group load is what removes the bubble
  // between vectors; it makes in_ready combinational on out_ready.
  assign in_ready  = (state == IDLE) || (issuing && !nxt_found);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    if (issuing && !nxt_found) state_nxt = IDLE;
    // A same-cycle accept wins over the return to IDLE.
    if (accept) state_nxt = first_found ? ISSUE : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grp       <= '0;
      cap_data  <= '0;
      cap_mask  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_group <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (slot_free) out_valid <= 1'b0;
      if (issuing) begin
        out_valid <= 1'b1;
        out_data  <= cap_data[int'(grp)*WIDTH_OUT +: WIDTH_OUT];
        out_mask  <= cap_mask[int'(grp)*WIDTH_OUT +: WIDTH_OUT];
        out_group <= grp;
        out_last  <= !nxt_found;
        if (nxt_found) grp <= nxt_grp;
      end
      // Only coincides with issuing on the last load, so no grp conflict.
      if (accept) begin
        cap_data <= in_data;
        cap_mask <= in_mask;
        grp      <= first_grp;
      end
    end
  end

endmodule
